// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and the pipeline sideband type for the multi-channel FIR
package fir_pkg;
  localparam int FIR_MC_DATA_WIDTH   = 8;
  localparam int FIR_MC_COEF_WIDTH   = 8;
  localparam int FIR_MC_NUM_TAPS     = 8;
  localparam int FIR_MC_NUM_CHANNELS = 4;
  localparam int FIR_MC_SIDE_W       = 32;
  typedef struct packed {
    logic                            valid;
    logic        [FIR_MC_SIDE_W-1:0] channel;
    logic                            bypass;
    logic signed [FIR_MC_SIDE_W-1:0] raw;
  } t_fir_mc_stage;
endpackage

// File: rtl/fir_mc_coef_bank.sv
// fir_mc_coef_bank: shadow/active coefficient banks with atomic commit, export aligned to the product stage
module fir_mc_coef_bank import fir_pkg::*; #(
  parameter int COEF_WIDTH = FIR_MC_COEF_WIDTH,
  parameter int NUM_TAPS   = FIR_MC_NUM_TAPS,
  parameter int AW         = $clog2(NUM_TAPS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_we,
  input  logic [AW-1:0]                i_addr,
  input  logic signed [COEF_WIDTH-1:0] i_data,
  input  logic                         i_commit,
  output logic signed [COEF_WIDTH-1:0] o_coef [NUM_TAPS]
);
  logic signed [COEF_WIDTH-1:0] r_shadow [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] r_active [NUM_TAPS];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
        o_coef[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (i_we && i_addr == AW'(k)) r_shadow[k] <= i_data;
        if (i_commit) r_active[k] <= (i_we && i_addr == AW'(k)) ? i_data : r_shadow[k];
        o_coef[k] <= r_active[k];
      end
    end
endmodule

// File: rtl/fir_mc.sv
// fir_mc: multi-channel FIR with shared double-buffered coefficients, rounding, saturation, bypass, flush; latency 4
module fir_mc import fir_pkg::*; #(
  parameter  int DATA_WIDTH   = FIR_MC_DATA_WIDTH,
  parameter  int COEF_WIDTH   = FIR_MC_COEF_WIDTH,
  parameter  int NUM_TAPS     = FIR_MC_NUM_TAPS,
  parameter  int NUM_CHANNELS = FIR_MC_NUM_CHANNELS,
  parameter  int SHIFT        = 0,
  localparam int ACC_WIDTH    = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS),
  localparam int CH_W         = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
  localparam int AW           = $clog2(NUM_TAPS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic signed [DATA_WIDTH-1:0] i_data_in,
  input  logic [CH_W-1:0]              i_channel_in,
  input  logic                         i_valid_in,
  input  logic                         i_coef_we,
  input  logic [AW-1:0]                i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] i_coef_data,
  input  logic                         i_coef_commit,
  input  logic                         i_bypass,
  input  logic                         i_flush,
  output logic signed [DATA_WIDTH-1:0] o_data_out,
  output logic [CH_W-1:0]              o_channel_out,
  output logic                         o_valid_out,
  output logic                         o_chan_err
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int SW = ACC_WIDTH + 1 > FIR_MC_SIDE_W ? ACC_WIDTH + 1 : FIR_MC_SIDE_W;
  localparam logic signed [SW-1:0] RND  = (SW'(1) << SHIFT) >> 1;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) << (DATA_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);
  logic                         w_accept;
  logic signed [COEF_WIDTH-1:0] w_coef [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] r_line [NUM_CHANNELS][NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] w_tap [NUM_TAPS];
  logic signed [PW-1:0]         r_prod [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  w_sum, r_sum;
  logic signed [SW-1:0]         w_val;
  t_fir_mc_stage                r_s1, r_s2, r_s3;
  assign w_accept = i_valid_in && 32'(i_channel_in) < NUM_CHANNELS;
  fir_mc_coef_bank #(.COEF_WIDTH(COEF_WIDTH), .NUM_TAPS(NUM_TAPS), .AW(AW)) u_coef (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_coef_we), .i_addr(i_coef_addr),
    .i_data(i_coef_data), .i_commit(i_coef_commit), .o_coef(w_coef)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        for (int k = 0; k < NUM_TAPS; k++) r_line[c][k] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (w_accept && 32'(i_channel_in) == 32'(c)) begin
          r_line[c][0] <= i_data_in;
          for (int k = 1; k < NUM_TAPS; k++) r_line[c][k] <= i_flush ? '0 : r_line[c][k-1];
        end else if (i_flush) begin
          for (int k = 0; k < NUM_TAPS; k++) r_line[c][k] <= '0;
        end
    end
  always_comb begin
    w_tap = r_line[0];
    for (int c = 1; c < NUM_CHANNELS; c++) if (r_s1.channel == 32'(c)) w_tap = r_line[c];
  end
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) w_sum = w_sum + ACC_WIDTH'(r_prod[k]);
  end
  assign w_val = r_s3.bypass ? SW'(r_s3.raw) : (SW'(r_sum) + RND) >>> SHIFT;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_sum <= '0;
      for (int k = 0; k < NUM_TAPS; k++) r_prod[k] <= '0;
    end else begin
      r_s1  <= '{valid: w_accept, channel: FIR_MC_SIDE_W'(i_channel_in), bypass: i_bypass, raw: FIR_MC_SIDE_W'(i_data_in)};
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_sum <= w_sum;
      for (int k = 0; k < NUM_TAPS; k++) r_prod[k] <= PW'(w_tap[k]) * PW'(w_coef[k]);
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data_out    <= '0;
      o_channel_out <= '0;
      o_valid_out   <= 1'b0;
      o_chan_err    <= 1'b0;
    end else begin
      o_valid_out <= r_s3.valid && r_s3.channel < NUM_CHANNELS;
      o_chan_err  <= o_chan_err || (i_valid_in && !w_accept);
      if (r_s3.valid) begin
        o_data_out    <= w_val > MAXV ? MAXV[DATA_WIDTH-1:0] : w_val < MINV ? MINV[DATA_WIDTH-1:0] : w_val[DATA_WIDTH-1:0];
        o_channel_out <= r_s3.channel[CH_W-1:0];
      end
    end
endmodule

// File: tb/tb_fir_mc.sv
// tb_fir_mc: scoreboard bench driving a 4-channel SHIFT=0 and a 3-channel SHIFT=7 instance from one reference model
module tb_fir_mc;
  typedef struct {int ch; int val; int cyc;} exp_t;
  logic clk = 0, rst_n = 0;
  logic signed [7:0] data_in = 0, coef_data = 0;
  logic [1:0] channel_in = 0;
  logic [2:0] coef_addr = 0;
  logic valid_in = 0, coef_we = 0, coef_commit = 0, bypass = 0, flush = 0;
  logic signed [7:0] a_data, b_data;
  logic [1:0] a_ch, b_ch;
  logic a_valid, b_valid, a_err, b_err;
  int errors = 0, checks = 0, cyc = 0;
  exp_t qa[$], qb[$];
  int line [2][4][8];
  int shadow [8];
  int active [8];
  bit err_exp [2];

  fir_mc dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_channel_in(channel_in), .i_valid_in(valid_in),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data), .i_coef_commit(coef_commit),
    .i_bypass(bypass), .i_flush(flush), .o_data_out(a_data), .o_channel_out(a_ch), .o_valid_out(a_valid),
    .o_chan_err(a_err)
  );
  fir_mc #(.NUM_CHANNELS(3), .SHIFT(7)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_channel_in(channel_in), .i_valid_in(valid_in),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data), .i_coef_commit(coef_commit),
    .i_bypass(bypass), .i_flush(flush), .o_data_out(b_data), .o_channel_out(b_ch), .o_valid_out(b_valid),
    .o_chan_err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      err_exp[u] = 0;
      for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) line[u][c][k] = 0;
    end
    for (int k = 0; k < 8; k++) begin shadow[k] = 0; active[k] = 0; end
    qa.delete();
    qb.delete();
  endtask

  task automatic idle_inputs();
    valid_in = 0; bypass = 0; flush = 0; coef_we = 0; coef_commit = 0;
  endtask

  // One clock cycle of stimulus; the reference model consumes the same inputs
  task automatic step(bit v, int ch, int d, bit byp = 0, bit fl = 0, bit we = 0, int a = 0, int cd = 0, bit cm = 0);
    @(posedge clk); #1;
    valid_in = v; channel_in = 2'(ch); data_in = 8'(d); bypass = byp; flush = fl;
    coef_we = we; coef_addr = 3'(a); coef_data = 8'(cd); coef_commit = cm;
    for (int u = 0; u < 2; u++) begin
      int nch; int sh; int acc; exp_t e;
      nch = (u == 1) ? 3 : 4;
      sh  = (u == 1) ? 7 : 0;
      if (fl) for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) line[u][c][k] = 0;
      if (v && ch >= nch) err_exp[u] = 1;
      else if (v) begin
        for (int k = 7; k > 0; k--) line[u][ch][k] = line[u][ch][k-1];
        line[u][ch][0] = d;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += active[k] * line[u][ch][k];
        if (sh > 0) acc = (acc + (1 << (sh - 1))) >>> sh;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        e.ch = ch; e.val = byp ? d : acc; e.cyc = cyc;
        if (u == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    if (we) shadow[a] = cd;
    if (cm) active = shadow;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic load(int base, int inc);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0, 1, k, base + inc * k);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) if (rst_n && a_valid) begin
    if (qa.size() == 0) begin
      checks++; errors++;
      $display("FAIL a_extra: valid_out with data %0d channel %0d, none expected", a_data, a_ch);
    end else begin
      exp_t e;
      e = qa.pop_front();
      chk("a_data", int'(a_data), e.val);
      chk("a_chan", int'(a_ch), e.ch);
      chk("a_latency", cyc - e.cyc, 4);
    end
  end

  always @(negedge clk) if (rst_n && b_valid) begin
    if (qb.size() == 0) begin
      checks++; errors++;
      $display("FAIL b_extra: valid_out with data %0d channel %0d, none expected", b_data, b_ch);
    end else begin
      exp_t e;
      e = qb.pop_front();
      chk("b_data", int'(b_data), e.val);
      chk("b_chan", int'(b_ch), e.ch);
      chk("b_latency", cyc - e.cyc, 4);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", int'(a_valid), 0); chk("rst_a_data", int'(a_data), 0);
    chk("rst_a_chan", int'(a_ch), 0);     chk("rst_a_err", int'(a_err), 0);
    chk("rst_b_valid", int'(b_valid), 0); chk("rst_b_data", int'(b_data), 0);
    rst_n = 1;
    load(1, 1);
    step(1, 0, 1);
    repeat (7) step(1, 0, 0);
    idle(6);
    load(127, 0);
    repeat (8) step(1, 1, 127);
    repeat (8) step(1, 1, -128);
    idle(6);
    load(64, 0);
    step(1, 0, 3, 0, 1);
    idle(6);
    load(1, 1);
    step(0, 0, 0, 0, 1);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) step(1, c, (r == 0 && c == 2) ? 1 : 0);
    idle(6);
    load(1, 0);
    step(0, 0, 0, 0, 1);
    repeat (10) step(1, 0, 1);
    for (int k = 0; k < 8; k++) step(1, 0, 1, 0, 0, 1, k, 2);
    step(1, 0, 1, 0, 0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 1);
    idle(6);
    load(1, 0);
    repeat (8) step(1, 1, 5);
    step(1, 1, 5, 0, 1);
    step(1, 1, 9, 1);
    idle(6);
    repeat (400)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128, $urandom_range(0, 15) == 0);
    idle(6);
    chk("a_err_random", int'(a_err), int'(err_exp[0]));
    chk("b_err_random", int'(b_err), int'(err_exp[1]));
    step(1, 0, 10);
    step(1, 1, 20);
    step(1, 2, 30);
    @(posedge clk); #3;
    rst_n = 0;
    idle_inputs();
    #1;
    chk("mid_rst_a_valid", int'(a_valid), 0); chk("mid_rst_a_data", int'(a_data), 0);
    chk("mid_rst_a_chan", int'(a_ch), 0);     chk("mid_rst_b_valid", int'(b_valid), 0);
    chk("mid_rst_b_data", int'(b_data), 0);   chk("mid_rst_b_err", int'(b_err), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    load(1, 1);
    step(1, 0, 1);
    repeat (7) step(1, 0, 0);
    idle(6);
    step(1, 3, 50);
    step(0, 0, 0);
    chk("b_err_set", int'(b_err), 1);
    chk("a_err_clear", int'(a_err), 0);
    idle(8);
    chk("b_err_sticky", int'(b_err), int'(err_exp[1]));
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_mc.md
# fir_mc

Parametrised, multi-channel successor of the single-channel 8-bit `fir` datapath that sits between `fir_requestor` and the CCI-P host buffers. It filters up to NUM_CHANNELS time-interleaved sample streams with independent delay lines and one shared, runtime-reloadable coefficient set. The coefficients are double-buffered with an atomic commit. The block adds rounding, saturation, bypass and flush behaviour, and has a fixed 4-cycle pipeline latency.

## Interface
- DATA_WIDTH, 8: signed sample width.
- COEF_WIDTH, 8: signed coefficient width.
- NUM_TAPS, 8: taps per channel, ≥2.
- NUM_CHANNELS, 4: independent delay lines, ≥1.
- SHIFT, 0: right shift applied to the accumulator before saturation.
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS): derived, not overridable.
- CH_W, max(1,$clog2(NUM_CHANNELS)): derived width of the channel tag.

- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- data_in  in  DATA_WIDTH  input sample.
- channel_in  in  CH_W  channel tag of the input sample.
- valid_in  in  1  qualifies data_in and channel_in.
- coef_we  in  1  writes coef_data into shadow coefficient coef_addr.
- coef_addr  in  $clog2(NUM_TAPS)  shadow coefficient index.
- coef_data  in  COEF_WIDTH  signed coefficient.
- coef_commit  in  1  one-cycle pulse that copies shadow→active.
- bypass  in  1  output the raw sample instead of the filtered value.
- flush  in  1  one-cycle pulse that zeroes all delay lines.
- data_out  out  DATA_WIDTH  filtered sample.
- channel_out  out  CH_W  tag accompanying data_out.
- valid_out  out  1  qualifies data_out and channel_out.
- chan_err  out  1  sticky flag; cleared only by reset.

## Operation
- **Accept:** a sample is accepted when valid_in=1 and channel_in<NUM_CHANNELS. Only delay line[channel_in] shifts: tap0←data_in, tap k←tap k-1. All other lines hold.
- **Illegal channel:** valid_in=1 with channel_in≥NUM_CHANNELS drops the sample, sets chan_err and produces no valid_out.
- **Filter:** y = Σ_{k} active_coef[k]·tap_k, computed on the line state after the shift. All products are full-precision signed and the sum is in ACC_WIDTH.
- **Round and saturate:** if SHIFT>0, add 1<<(SHIFT-1), then arithmetic shift right by SHIFT. Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Bypass:** with bypass=1 at accept, data_out=data_in at the same latency. The delay line still shifts. bypass is sampled per sample and travels down the pipeline with it.
- **Coefficient load:** coef_we writes the shadow bank only. The active bank changes only on coef_commit.
- **Commit timing:** a commit in cycle t applies to samples accepted at t+1 and later. Samples accepted at ≤t use the old bank for the whole pipeline.
- **Same-cycle write and commit:** coef_we and coef_commit in the same cycle commit the shadow bank including the new write.
- **Flush:** zeroes all delay lines at the clock edge.
  - A sample accepted in the flush cycle is shifted into the zeroed line, so its result uses only itself at tap0.
  - Samples already in the pipeline complete unchanged.
  - Coefficients are untouched.
- **Reset:**
  - Delay lines, both coefficient banks, pipeline valids and chan_err clear to 0.
  - data_out=0, channel_out=0, valid_out=0.
  - Reset mid-stream discards in-flight samples. No valid_out appears until 4 cycles after the first accepted sample following reset release.

## Timing
- **Pipeline, fixed latency 4:**
  - S1: delay-line register update with sample, tag and bypass captured.
  - S2: product registers.
  - S3: adder-tree sum register.
  - S4: round/saturate and output registers.
- **Relation to input:** valid_out at cycle t+4 for a sample accepted at t, with channel_out equal to its tag.
- **Throughput:** one sample per cycle, any channel order, back-to-back on the same channel allowed. No backpressure.
- **Idle:** valid_out=0 when no sample was accepted 4 cycles earlier. data_out holds its last value.
- **chan_err:** rises in the cycle after the illegal request.

## Structure
- **fir_pkg additions:**
  - Default parameter constants FIR_MC_DATA_WIDTH, FIR_MC_COEF_WIDTH, FIR_MC_NUM_TAPS, FIR_MC_NUM_CHANNELS.
  - A t_fir_mc_stage struct {valid, channel, bypass, raw} for pipeline sideband.
- **Sub-module `fir_mc_coef_bank`:** shadow and active registers, write/commit logic, active bank exported as an array.
- The adder tree is inline in fir_mc.

## Test plan
- **Impulse:** coefs 1..8, SHIFT=0, channel 0 sequence 1,0,0,0,0,0,0,0 → valid_out from cycle 4 with data_out 1,2,3,4,5,6,7,8 on channel 0.
- **Saturation:** all coefs 127, 8 samples of 127 → data_out 127. All coefs 127, 8 samples of -128 → data_out -128. SHIFT=7 with coefs 64 and a single impulse of 3 → 2 (rounded).
- **Interleave:** channels 0,1,2,3 round-robin, impulse only on channel 2, coefs 1..8 → channel 2 outputs 1..8. Channels 0,1,3 output 0. Tags are in order at latency 4.
- **Commit mid-stream:** constant input 1, coefs all 1 (output 8). Rewrite shadow to all 2 without commit → outputs stay 8. Commit at t → sample accepted at t+1 gives 16 and sample at t gives 8.
- **Flush, bypass, illegal channel:**
  - Flush after 8 samples of 5 with coefs all 1, then a sample of 5 → 5.
  - bypass=1 for sample 9 → 9 at latency 4.
  - NUM_CHANNELS=3 with channel_in=3 → no valid_out, chan_err=1 until reset.
- **Reset mid-operation:** assert reset with 3 samples in flight → all outputs 0 immediately (asynchronous). After release, no valid_out for 4 cycles and the delay lines read back as zero via an impulse response.
